// File: rtl/ctrl_saxi.sv
// AXI4 slave control-register file: start pulse, sticky done, argument regs.
// Define CTRL_SAXI_ERR_RESP_EN for SLVERR on out-of-range register beats.
module ctrl_saxi #(
    parameter int AXI_AWIDTH = 64,
    parameter int AXI_DWIDTH = 512,
    parameter int NUM_REGS   = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [3:0]              s0_awid,
    input  logic [AXI_AWIDTH-1:0]   s0_awaddr,
    input  logic [7:0]              s0_awlen,
    input  logic [2:0]              s0_awsize,
    input  logic [1:0]              s0_awburst,
    input  logic                    s0_awvalid,
    output logic                    s0_awready,
    input  logic [3:0]              s0_wid,
    input  logic [AXI_DWIDTH-1:0]   s0_wdata,
    input  logic [AXI_DWIDTH/8-1:0] s0_wstrb,
    input  logic                    s0_wlast,
    input  logic                    s0_wvalid,
    output logic                    s0_wready,
    output logic [3:0]              s0_bid,
    output logic [1:0]              s0_bresp,
    output logic                    s0_bvalid,
    input  logic                    s0_bready,
    input  logic [3:0]              s0_arid,
    input  logic [AXI_AWIDTH-1:0]   s0_araddr,
    input  logic [7:0]              s0_arlen,
    input  logic [2:0]              s0_arsize,
    input  logic [1:0]              s0_arburst,
    input  logic                    s0_arvalid,
    output logic                    s0_arready,
    output logic [3:0]              s0_rid,
    output logic [AXI_DWIDTH-1:0]   s0_rdata,
    output logic [1:0]              s0_rresp,
    output logic                    s0_rlast,
    output logic                    s0_rvalid,
    input  logic                    s0_rready,
    output logic                    socket_start,
    input  logic                    socket_done,
    output logic [NUM_REGS*32-1:0]  ctrl_regs_q
);

`ifdef CTRL_SAXI_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int LB = $clog2(AXI_DWIDTH / 8);
    localparam int IW = $clog2(NUM_REGS);
    localparam int FW = AXI_AWIDTH - LB;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e        w_state, w_next;
    r_state_e        r_state, r_next;
    logic            out_en;
    logic [3:0]      w_id, r_id;
    logic [FW-1:0]   w_idx, r_idx, r_ld_idx;
    logic [7:0]      w_len, w_cnt, r_len, r_cnt;
    logic            w_err, r_err;
    logic [31:0]     r_data;
    logic [31:0]     regs [NUM_REGS];
    logic            aw_fire, w_fire, ar_fire, r_fire;
    logic            w_oor, w_we, r_last, r_ld_oor;
    logic [IW-1:0]   w_ri;
    logic [31:0]     w_mask, w_val, r_ld_val;
    logic            start_q;

    logic unused_ok;
    assign unused_ok = ^{s0_awaddr[LB-1:0], s0_awsize, s0_awburst,
                         s0_araddr[LB-1:0], s0_arsize, s0_arburst,
                         s0_wid, s0_wlast, s0_wdata[AXI_DWIDTH-1:32],
                         s0_wstrb[AXI_DWIDTH/8-1:4]};

    assign aw_fire = s0_awvalid & s0_awready;
    assign w_fire  = s0_wvalid & s0_wready;
    assign ar_fire = s0_arvalid & s0_arready;
    assign r_fire  = s0_rvalid & s0_rready;

    // Handshake readies stay low until the first cycle after reset release
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) out_en <= 1'b0;
        else         out_en <= 1'b1;
    end

    always_comb begin
        w_next     = w_state;
        s0_awready = 1'b0;
        s0_wready  = 1'b0;
        s0_bvalid  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                s0_awready = out_en;
                if (s0_awvalid && out_en) w_next = W_DATA;
            end
            W_DATA: begin
                s0_wready = 1'b1;
                if (s0_wvalid && w_cnt == w_len) w_next = W_RESP;
            end
            W_RESP: begin
                s0_bvalid = 1'b1;
                if (s0_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign w_oor    = ERR_EN && (w_idx >= FW'(NUM_REGS));
    assign s0_bid   = w_id;
    assign s0_bresp = {w_err, 1'b0};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_idx   <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else begin
            w_state <= w_next;
            if (aw_fire) begin
                w_id  <= s0_awid;
                w_idx <= s0_awaddr[AXI_AWIDTH-1:LB];
                w_len <= s0_awlen;
                w_cnt <= '0;
                w_err <= 1'b0;
            end else if (w_fire) begin
                w_cnt <= w_cnt + 8'd1;
                w_idx <= w_idx + FW'(1);
                if (w_oor) w_err <= 1'b1;
            end
        end
    end

    assign w_ri = w_idx[IW-1:0];
    assign w_we = w_fire & ~w_oor;
    assign w_val = s0_wdata[31:0];

    always_comb begin
        for (int b = 0; b < 4; b++) w_mask[8*b +: 8] = {8{s0_wstrb[b]}};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= w_we && w_ri == '0 && s0_wstrb[0] && w_val[0];
            if (w_we && w_ri == '0)
                regs[0] <= ((regs[0] & ~w_mask) | (w_val & w_mask)) & ~32'h1;
            // Set beats clear: a done event never gets lost to a W1C
            if (socket_done)
                regs[1][0] <= 1'b1;
            else if (w_we && w_ri == IW'(1) && s0_wstrb[0] && w_val[0])
                regs[1][0] <= 1'b0;
            for (int i = 2; i < NUM_REGS; i++) begin
                if (w_we && w_ri == IW'(i))
                    regs[i] <= (regs[i] & ~w_mask) | (w_val & w_mask);
            end
        end
    end

    assign socket_start = start_q;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) ctrl_regs_q[32*i +: 32] = regs[i];
    end

    always_comb begin
        r_next     = r_state;
        s0_arready = 1'b0;
        s0_rvalid  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                s0_arready = out_en;
                if (s0_arvalid && out_en) r_next = R_DATA;
            end
            R_DATA: begin
                s0_rvalid = 1'b1;
                if (s0_rready && r_last) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Index of the beat loaded next: burst start, or the following beat
    assign r_ld_idx = (r_state == R_IDLE) ? s0_araddr[AXI_AWIDTH-1:LB]
                                          : r_idx + FW'(1);
    assign r_ld_oor = ERR_EN && (r_ld_idx >= FW'(NUM_REGS));
    assign r_ld_val = r_ld_oor ? 32'h0 : regs[r_ld_idx[IW-1:0]];
    assign r_last   = (r_cnt == r_len);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= r_next;
            if (ar_fire) begin
                r_id   <= s0_arid;
                r_len  <= s0_arlen;
                r_cnt  <= '0;
                r_idx  <= r_ld_idx;
                r_data <= r_ld_val;
                r_err  <= r_ld_oor;
            end else if (r_fire && !r_last) begin
                r_cnt  <= r_cnt + 8'd1;
                r_idx  <= r_ld_idx;
                r_data <= r_ld_val;
                r_err  <= r_ld_oor;
            end
        end
    end

    assign s0_rid   = r_id;
    assign s0_rdata = {{(AXI_DWIDTH-32){1'b0}}, r_data};
    assign s0_rresp = {s0_rvalid & r_err, 1'b0};
    assign s0_rlast = s0_rvalid & r_last;

endmodule

// File: tb/tb_ctrl_saxi.sv
// Directed bench for ctrl_saxi: register access, start/done, bursts, wrap.
// Build with CTRL_SAXI_ERR_RESP_EN to check the out-of-range responses.
module tb_ctrl_saxi;

    logic         clk = 1'b0;
    logic         resetn;
    logic [3:0]   s0_awid, s0_arid, s0_wid;
    logic [63:0]  s0_awaddr, s0_araddr;
    logic [7:0]   s0_awlen, s0_arlen;
    logic [2:0]   s0_awsize, s0_arsize;
    logic [1:0]   s0_awburst, s0_arburst;
    logic         s0_awvalid, s0_awready, s0_arvalid, s0_arready;
    logic [511:0] s0_wdata, s0_rdata;
    logic [63:0]  s0_wstrb;
    logic         s0_wlast, s0_wvalid, s0_wready;
    logic [3:0]   s0_bid, s0_rid;
    logic [1:0]   s0_bresp, s0_rresp;
    logic         s0_bvalid, s0_bready;
    logic         s0_rlast, s0_rvalid, s0_rready;
    logic         socket_start, socket_done;
    logic [511:0] ctrl_regs_q;

    int n_chk = 0;
    int n_err = 0;

    ctrl_saxi dut (
        .clk(clk), .resetn(resetn),
        .s0_awid(s0_awid), .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen),
        .s0_awsize(s0_awsize), .s0_awburst(s0_awburst),
        .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
        .s0_wid(s0_wid), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
        .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
        .s0_bid(s0_bid), .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid),
        .s0_bready(s0_bready),
        .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
        .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
        .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .socket_start(socket_start), .socket_done(socket_done),
        .ctrl_regs_q(ctrl_regs_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] reg_q(input int i);
        return ctrl_regs_q[32*i +: 32];
    endfunction

    task automatic aw_send(input logic [63:0] addr, input logic [7:0] len,
                           input logic [3:0] id);
        int n = 0;
        s0_awaddr = addr; s0_awlen = len; s0_awid = id; s0_awvalid = 1'b1;
        while (!s0_awready && n < 20) begin tick; n++; end
        if (!s0_awready) chk("aw_timeout", 0, 1);
        tick;
        s0_awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] strb,
                          input logic done);
        int n = 0;
        s0_wdata = '0; s0_wdata[31:0] = d;
        s0_wstrb = '0; s0_wstrb[3:0] = strb;
        s0_wvalid = 1'b1;
        while (!s0_wready && n < 20) begin tick; n++; end
        if (!s0_wready) chk("w_timeout", 0, 1);
        socket_done = done;
        tick;
        socket_done = 1'b0;
        s0_wvalid = 1'b0;
    endtask

    task automatic b_take(input int stall, input logic [3:0] id,
                          input logic [1:0] resp);
        for (int i = 0; i < stall; i++) tick;
        chk("bvalid", s0_bvalid, 1);
        chk("bid", s0_bid, id);
        chk("bresp", s0_bresp, resp);
        s0_bready = 1'b1;
        tick;
        s0_bready = 1'b0;
    endtask

    task automatic ar_send(input logic [63:0] addr, input logic [7:0] len,
                           input logic [3:0] id);
        int n = 0;
        s0_araddr = addr; s0_arlen = len; s0_arid = id; s0_arvalid = 1'b1;
        while (!s0_arready && n < 20) begin tick; n++; end
        if (!s0_arready) chk("ar_timeout", 0, 1);
        tick;
        s0_arvalid = 1'b0;
    endtask

    task automatic r_beat(input string tag, input logic [31:0] d,
                          input logic last, input logic [1:0] resp);
        chk({tag, "_rvalid"}, s0_rvalid, 1);
        chk({tag, "_rdata"}, s0_rdata[63:0], {32'h0, d});
        chk({tag, "_rlast"}, s0_rlast, last);
        chk({tag, "_rresp"}, s0_rresp, resp);
        s0_rready = 1'b1;
        tick;
        s0_rready = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        s0_awid = '0; s0_awaddr = '0; s0_awlen = '0; s0_awsize = 3'd6;
        s0_awburst = 2'd1; s0_awvalid = 1'b0; s0_wid = '0; s0_wdata = '0;
        s0_wstrb = '0; s0_wlast = 1'b0; s0_wvalid = 1'b0; s0_bready = 1'b0;
        s0_arid = '0; s0_araddr = '0; s0_arlen = '0; s0_arsize = 3'd6;
        s0_arburst = 2'd1; s0_arvalid = 1'b0; s0_rready = 1'b0;
        socket_done = 1'b0;
        tick; tick;
        chk("rst_awready", s0_awready, 0);
        chk("rst_arready", s0_arready, 0);
        chk("rst_valids", {s0_bvalid, s0_rvalid, s0_wready}, 0);
        chk("rst_start", socket_start, 0);
        chk("rst_regs", 64'(|ctrl_regs_q), 0);
        resetn = 1'b1;
        tick; tick;

        aw_send(64'h80, 8'd0, 4'd3);
        w_beat(32'hDEADBEEF, 4'hF, 1'b0);
        chk("b_latency", s0_bvalid, 1);
        chk("reg2_val", reg_q(2), 32'hDEADBEEF);
        b_take(0, 4'd3, 2'b00);

        ar_send(64'h80, 8'd0, 4'd5);
        chk("rid", s0_rid, 5);
        r_beat("rd_reg2", 32'hDEADBEEF, 1'b1, 2'b00);
        chk("r_idle", s0_rvalid, 0);

        aw_send(64'h0, 8'd0, 4'd1);
        w_beat(32'h0000_0101, 4'hF, 1'b0);
        chk("start_hi", socket_start, 1);
        b_take(0, 4'd1, 2'b00);
        chk("start_lo", socket_start, 0);
        ar_send(64'h0, 8'd0, 4'd1);
        r_beat("rd_reg0", 32'h0000_0100, 1'b1, 2'b00);

        socket_done = 1'b1;
        tick;
        socket_done = 1'b0;
        ar_send(64'h40, 8'd0, 4'd2);
        r_beat("rd_done", 32'h1, 1'b1, 2'b00);
        aw_send(64'h40, 8'd0, 4'd2);
        w_beat(32'h1, 4'h1, 1'b0);
        b_take(0, 4'd2, 2'b00);
        chk("w1c", reg_q(1), 32'h0);
        aw_send(64'h40, 8'd0, 4'd2);
        w_beat(32'hFFFF_FFFF, 4'hF, 1'b1);
        b_take(0, 4'd2, 2'b00);
        chk("set_wins", reg_q(1), 32'h1);

        aw_send(64'h80, 8'd3, 4'd9);
        for (int i = 1; i <= 4; i++) w_beat(32'(i), 4'hF, 1'b0);
        b_take(5, 4'd9, 2'b00);
        for (int i = 0; i < 4; i++) chk($sformatf("burst_reg%0d", i + 2),
                                         reg_q(i + 2), 32'(i + 1));

        aw_send(64'h180, 8'd0, 4'd4);
        w_beat(32'hAABBCCDD, 4'hF, 1'b0);
        b_take(0, 4'd4, 2'b00);
        aw_send(64'h180, 8'd0, 4'd4);
        w_beat(32'h11223344, 4'h2, 1'b0);
        b_take(0, 4'd4, 2'b00);
        chk("strb", reg_q(6), 32'hAABB33DD);

        ar_send(64'h80, 8'd1, 4'd7);
        s0_rready = 1'b0;
        tick;
        chk("r_hold", s0_rdata[31:0], 32'h1);
        chk("r_hold_last", s0_rlast, 0);
        r_beat("rb0", 32'h1, 1'b0, 2'b00);
        r_beat("rb1", 32'h2, 1'b1, 2'b00);

        aw_send(64'h3C0, 8'd1, 4'd6);
        w_beat(32'h55, 4'hF, 1'b0);
        w_beat(32'h66, 4'hF, 1'b0);
`ifdef CTRL_SAXI_ERR_RESP_EN
        b_take(0, 4'd6, 2'b10);
        chk("oor_discard", reg_q(0), 32'h100);
`else
        b_take(0, 4'd6, 2'b00);
        chk("wrap_reg0", reg_q(0), 32'h66);
`endif
        chk("wrap_reg15", reg_q(15), 32'h55);

        ar_send(64'h400, 8'd0, 4'd8);
`ifdef CTRL_SAXI_ERR_RESP_EN
        r_beat("rd_oor", 32'h0, 1'b1, 2'b10);
`else
        r_beat("rd_alias", 32'h66, 1'b1, 2'b00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
